// File: rtl/dpwm_generador_10b.sv
// -----------------------------------------------------------------------------
// dpwm_generador_10b
//
// Converts the 10-bit duty set-point (0..PERIODO) into a complementary
// high-side / low-side PWM pair with programmable dead time. The requested
// duty is saturated to PERIODO and double-buffered: while running, it is only
// copied into the active (shadow) register on the last cycle of a period, so
// a set-point change never cuts a running period short.
//
// Parameters
//   PERIODO  clk cycles per PWM period; also the duty ceiling (<= 1023)
//   MUERTO   dead-time cycles on every output transition (>= 1, < PERIODO/2)
//
// Ports
//   clk            in   1   system clock, all logic on posedge
//   reset          in   1   synchronous, active-high; priority over everything
//   enable         in   1   1 = run; 0 = outputs off, counter held at 0
//   ciclo_trabajo  in   10  requested duty in cycles of PERIODO (saturated)
//   pwm_alto       out  1   high-side drive, registered
//   pwm_bajo       out  1   low-side drive, registered
//   fin_periodo    out  1   one-cycle strobe on the last cycle of each period
//   duty_activo    out  10  duty currently applied (shadow register)
// -----------------------------------------------------------------------------
module dpwm_generador_10b #(
    parameter int unsigned PERIODO = 1000,
    parameter int unsigned MUERTO  = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic [9:0] ciclo_trabajo,
    output logic       pwm_alto,
    output logic       pwm_bajo,
    output logic       fin_periodo,
    output logic [9:0] duty_activo
);

    localparam logic [9:0] C_PERIODO = 10'(PERIODO);
    localparam logic [9:0] C_ULTIMO  = 10'(PERIODO - 1);
    localparam logic [9:0] C_MUERTO  = 10'(MUERTO);

    typedef enum logic [1:0] {
        APAGADO,
        ALTO,
        BAJO,
        MUERTO_ST
    } t_estado;

    // -------------------------------------------------------------------------
    // Period counter, shadow duty and period-end strobe
    // -------------------------------------------------------------------------
    logic [9:0] r_cont;
    logic [9:0] r_duty;
    logic       r_fin;

    logic [9:0] w_sat;
    logic       w_ultimo;
    logic [9:0] w_cont_next;
    logic       w_raw;

    always_comb begin
        w_sat = (ciclo_trabajo > C_PERIODO) ? C_PERIODO : ciclo_trabajo;
    end

    always_comb begin
        w_ultimo = (r_cont == C_ULTIMO);
    end

    always_comb begin
        w_cont_next = r_cont + 10'd1;
        if (!enable || w_ultimo) begin
            w_cont_next = '0;
        end
    end

    // Raw compare: duty 0 never asserts, duty PERIODO always asserts.
    always_comb begin
        w_raw = enable & (r_cont < r_duty);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cont <= '0;
            r_duty <= '0;
            r_fin  <= 1'b0;
        end else begin
            r_cont <= w_cont_next;
            // Strobe is registered from the next counter value so it is high
            // in the same cycle that the counter sits on PERIODO-1.
            r_fin  <= (w_cont_next == C_ULTIMO);
            // Stopped: track the set-point every cycle. Running: latch only at
            // the period boundary so the new duty applies from count 0.
            if (!enable || w_ultimo) begin
                r_duty <= w_sat;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Dead-time FSM: state register / next-state logic / output decode
    // -------------------------------------------------------------------------
    t_estado    r_estado;
    t_estado    w_estado_next;
    logic [9:0] r_muerto_cnt;
    logic [9:0] w_muerto_next;
    logic       r_alto;
    logic       r_bajo;
    logic       w_alto_d;
    logic       w_bajo_d;

    // State register; outputs are registered from the decoded next state so
    // they always match the state they belong to.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_estado     <= APAGADO;
            r_muerto_cnt <= '0;
            r_alto       <= 1'b0;
            r_bajo       <= 1'b0;
        end else begin
            r_estado     <= w_estado_next;
            r_muerto_cnt <= w_muerto_next;
            r_alto       <= w_alto_d;
            r_bajo       <= w_bajo_d;
        end
    end

    // Next-state logic
    always_comb begin
        w_estado_next = r_estado;
        w_muerto_next = r_muerto_cnt;
        case (r_estado)
            APAGADO: begin
                if (enable) begin
                    w_estado_next = MUERTO_ST;
                    w_muerto_next = C_MUERTO;
                end
            end
            ALTO: begin
                if (!enable) begin
                    w_estado_next = APAGADO;
                end else if (!w_raw) begin
                    w_estado_next = MUERTO_ST;
                    w_muerto_next = C_MUERTO;
                end
            end
            BAJO: begin
                if (!enable) begin
                    w_estado_next = APAGADO;
                end else if (w_raw) begin
                    w_estado_next = MUERTO_ST;
                    w_muerto_next = C_MUERTO;
                end
            end
            MUERTO_ST: begin
                // Loaded with MUERTO on entry and left when it reads 1, so the
                // gap is exactly MUERTO cycles. The exit side follows the raw
                // compare at that moment, which lets very short pulses vanish.
                if (!enable) begin
                    w_estado_next = APAGADO;
                end else if (r_muerto_cnt == 10'd1) begin
                    w_estado_next = w_raw ? ALTO : BAJO;
                end else begin
                    w_muerto_next = r_muerto_cnt - 10'd1;
                end
            end
            default: begin
                w_estado_next = APAGADO;
            end
        endcase
    end

    // Output decode (from next state, captured in the state register block)
    always_comb begin
        w_alto_d = (w_estado_next == ALTO);
        w_bajo_d = (w_estado_next == BAJO);
    end

    // -------------------------------------------------------------------------
    // Output ports
    // -------------------------------------------------------------------------
    assign pwm_alto    = r_alto;
    assign pwm_bajo    = r_bajo;
    assign fin_periodo = r_fin;
    assign duty_activo = r_duty;

endmodule

// File: tb/tb_dpwm_generador_10b.sv
// -----------------------------------------------------------------------------
// tb_dpwm_generador_10b
//
// Directed self-checking bench for dpwm_generador_10b with PERIODO=1000 and
// MUERTO=4. Expected values are hand-computed from the period/dead-time rules;
// a background monitor checks the no-overlap and strobe-width invariants.
// -----------------------------------------------------------------------------
module tb_dpwm_generador_10b;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic [9:0] ciclo;
    logic       pwm_alto;
    logic       pwm_bajo;
    logic       fin_periodo;
    logic [9:0] duty_activo;

    int   checks = 0;
    int   errors = 0;
    bit   mon_en = 1'b0;
    logic prev_fin = 1'b0;

    dpwm_generador_10b #(
        .PERIODO(1000),
        .MUERTO (4)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .ciclo_trabajo(ciclo),
        .pwm_alto     (pwm_alto),
        .pwm_bajo     (pwm_bajo),
        .fin_periodo  (fin_periodo),
        .duty_activo  (duty_activo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One clock: inputs are driven and outputs sampled on the falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Observe one whole period starting from a negedge where the counter is on
    // its last value. Sample i corresponds to counter value i.
    task automatic period(input int chg_at, input logic [9:0] chg_val,
                          output int na, output int nb, output int nz,
                          output int nf, output int d0);
        na = 0; nb = 0; nz = 0; nf = 0; d0 = 0;
        for (int i = 0; i < 1000; i++) begin
            tick();
            if (pwm_alto) na++;
            if (pwm_bajo) nb++;
            if (!pwm_alto && !pwm_bajo) nz++;
            if (fin_periodo) nf++;
            if (i == 0) d0 = 32'(duty_activo);
            if (i == chg_at) ciclo = chg_val;
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            chk("no_overlap", 32'(pwm_alto & pwm_bajo), 0);
            chk("fin_width", 32'(fin_periodo & prev_fin), 0);
            prev_fin <= fin_periodo;
        end
    end

    initial begin
        int na, nb, nz, nf, d0, n;

        reset  = 1'b1;
        enable = 1'b0;
        ciclo  = 10'd500;
        repeat (3) tick();
        mon_en = 1'b1;
        chk("rst_alto", 32'(pwm_alto), 0);
        chk("rst_bajo", 32'(pwm_bajo), 0);
        chk("rst_fin", 32'(fin_periodo), 0);
        chk("rst_duty", 32'(duty_activo), 0);

        // Stopped: shadow follows the set-point every cycle.
        reset = 1'b0;
        tick();
        chk("stop_duty_500", 32'(duty_activo), 500);
        chk("stop_alto", 32'(pwm_alto), 0);

        // Start: 4 dead cycles, then high side at count 5.
        enable = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("start_dead", 32'({pwm_alto, pwm_bajo}), 0);
        end
        tick();
        chk("start_alto", 32'(pwm_alto), 1);

        n = 0;
        while (fin_periodo !== 1'b1 && n < 2000) begin
            tick();
            n++;
        end
        chk("fin_latency", n, 994);

        // Steady state at duty 500.
        period(-1, 10'd0, na, nb, nz, nf, d0);
        chk("p500_alto", na, 496);
        chk("p500_bajo", nb, 496);
        chk("p500_zero", nz, 8);
        chk("p500_fin", nf, 1);
        chk("p500_fin_end", 32'(fin_periodo), 1);

        // Set-point change mid-period only applies from the next period.
        period(200, 10'd700, na, nb, nz, nf, d0);
        chk("chg_cur_alto", na, 496);
        chk("chg_cur_d0", d0, 500);
        chk("chg_cur_duty_end", 32'(duty_activo), 500);
        period(-1, 10'd0, na, nb, nz, nf, d0);
        chk("p700_d0", d0, 700);
        chk("p700_alto", na, 696);
        chk("p700_bajo", nb, 296);
        chk("p700_zero", nz, 8);

        // Saturation: 1023 -> 1000, high side continuous.
        ciclo = 10'd1023;
        period(-1, 10'd0, na, nb, nz, nf, d0);
        chk("sat_d0", d0, 1000);
        period(-1, 10'd0, na, nb, nz, nf, d0);
        chk("full_alto", na, 1000);
        chk("full_bajo", nb, 0);

        // Duty 0: low side continuous.
        ciclo = 10'd0;
        period(-1, 10'd0, na, nb, nz, nf, d0);
        chk("zero_d0", d0, 0);
        period(-1, 10'd0, na, nb, nz, nf, d0);
        chk("zero_alto", na, 0);
        chk("zero_bajo", nb, 1000);

        // Duty below dead time: high side never asserts, 4-cycle low-side gap.
        ciclo = 10'd3;
        period(-1, 10'd0, na, nb, nz, nf, d0);
        chk("tiny1_alto", na, 0);
        period(-1, 10'd0, na, nb, nz, nf, d0);
        chk("tiny_alto", na, 0);
        chk("tiny_bajo", nb, 996);
        chk("tiny_zero", nz, 4);

        // Reset mid-pulse at count 400.
        ciclo = 10'd500;
        repeat (401) tick();
        chk("pre_rst_alto", 32'(pwm_alto), 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("mid_rst_alto", 32'(pwm_alto), 0);
        chk("mid_rst_bajo", 32'(pwm_bajo), 0);
        chk("mid_rst_duty", 32'(duty_activo), 0);
        chk("mid_rst_fin", 32'(fin_periodo), 0);
        na = 0;
        for (int k = 0; k < 998; k++) begin
            tick();
            if (pwm_alto) na++;
        end
        chk("post_rst_alto", na, 0);
        chk("post_rst_fin998", 32'(fin_periodo), 0);
        tick();
        chk("post_rst_fin999", 32'(fin_periodo), 1);
        chk("post_rst_duty", 32'(duty_activo), 0);
        chk("post_rst_bajo", 32'(pwm_bajo), 1);

        // Enable drop mid-pulse.
        repeat (401) tick();
        chk("pre_dis_alto", 32'(pwm_alto), 1);
        enable = 1'b0;
        tick();
        chk("dis_alto", 32'(pwm_alto), 0);
        chk("dis_bajo", 32'(pwm_bajo), 0);
        chk("dis_fin", 32'(fin_periodo), 0);
        chk("dis_duty", 32'(duty_activo), 500);

        // Saturation boundary while stopped.
        ciclo = 10'd1001;
        tick();
        chk("sat_1001", 32'(duty_activo), 1000);
        ciclo = 10'd1000;
        tick();
        chk("sat_1000", 32'(duty_activo), 1000);
        ciclo = 10'd999;
        tick();
        chk("sat_999", 32'(duty_activo), 999);

        // Enable falling on the last-count edge: the stopped path wins.
        enable = 1'b1;
        repeat (998) tick();
        chk("edge_fin998", 32'(fin_periodo), 0);
        tick();
        chk("edge_fin999", 32'(fin_periodo), 1);
        ciclo  = 10'd250;
        enable = 1'b0;
        tick();
        chk("edge_fin", 32'(fin_periodo), 0);
        chk("edge_duty", 32'(duty_activo), 250);
        chk("edge_out", 32'({pwm_alto, pwm_bajo}), 0);

        // Random soak; invariants checked by the monitor.
        for (int k = 0; k < 20000; k++) begin
            reset  = ($urandom_range(0, 999) == 0);
            enable = ($urandom_range(0, 99) != 0);
            if ($urandom_range(0, 199) == 0) begin
                if ($urandom_range(0, 1) == 0)
                    ciclo = 10'($urandom_range(0, 1023));
                else if ($urandom_range(0, 1) == 0)
                    ciclo = 10'($urandom_range(0, 8));
                else
                    ciclo = 10'($urandom_range(992, 1023));
            end
            tick();
        end
        reset  = 1'b0;
        enable = 1'b0;
        tick();
        chk("end_off", 32'({pwm_alto, pwm_bajo}), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
